ex_mdu: RTL and testbench

Parametrised multi-cycle RV32M execute unit that sits beside the combinational `ex` stage and handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It accepts one operation from `id_ex` and holds the pipeline through `ctrl` while it computes. It iterates a radix-2 shift-add multiplier or a restoring divider, then writes the result back to `regs` with a single-cycle write-enable pulse. Divide-by-zero and signed overflow follow the RISC-V spec and bypass iteration.

---
 rtl/ex_mdu_pkg.sv | 21 ++
 rtl/ex_mdu_div.sv | 48 ++++
 rtl/ex_mdu.sv | 156 +++++++++++++++
 tb/tb_ex_mdu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// RV32M op codes and helpers shared by the multi-cycle multiply/divide unit.
// Purely declarative: no timing, no flow control.
// Nothing here is clocked or backpressured.
package ex_mdu_pkg;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    localparam logic [6:0] FUNC7_M = 7'b000_0001;

    function automatic logic is_m_func7(input logic [6:0] func7);
        return func7 == FUNC7_M;
    endfunction

endpackage

// File: rtl/ex_mdu_div.sv
// Restoring unsigned divider datapath, one quotient bit per step.
// Latency: XLEN steps after load; next-step quotient/remainder exposed combinationally.
// No backpressure: the owner decides when to load and when to step.
module ex_mdu_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot_nxt,
    output logic [XLEN-1:0] rem_nxt
);

    logic [XLEN-1:0] q_q, r_q, d_q;
    logic [XLEN:0]   part, diff;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        part = {r_q, q_q[XLEN-1]};
        diff = part - {1'b0, d_q};
        if (!diff[XLEN]) begin
            rem_nxt  = diff[XLEN-1:0];
            quot_nxt = {q_q[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt  = part[XLEN-1:0];
            quot_nxt = {q_q[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
            r_q <= '0;
            d_q <= '0;
        end else if (load) begin
            q_q <= dividend;
            r_q <= '0;
            d_q <= divisor;
        end else if (step) begin
            q_q <= quot_nxt;
            r_q <= rem_nxt;
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// RV32M execute unit: shift-add multiply / restoring divide, one bit per cycle.
// Latency: XLEN+1 cycles start-to-writeback, 1 cycle for divide-by-zero and signed overflow.
// Holds the pipeline via hold_flag_o while busy; flush_i kills the op and suppresses writeback.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_wen_i,
    input  logic            flush_i,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_wen_o,
    output logic            hold_flag_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int         CW      = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_nxt;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        func3_q;
    logic [4:0]        rd_addr_q;
    logic              rd_wen_q, neg_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] prod_q, prod_nxt, prod_s;
    logic [XLEN:0]     mul_sum;

    logic              accept, sgn1, sgn2, neg1, neg2, neg_res;
    logic              div_zero, div_ovf, special, last_step;
    logic [XLEN-1:0]   abs1, abs2, special_res, calc_res;
    logic [XLEN-1:0]   quot_nxt, rem_nxt;

    assign accept    = (state_q == ST_IDLE) && start_i && !flush_i;
    assign last_step = (state_q == ST_CALC) && (cnt_q == CW'(1));

    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        case (func3_i)
            INST_MUL, INST_MULH, INST_DIV, INST_REM: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            INST_MULHSU:                    sgn1 = 1'b1;
            INST_MULHU, INST_DIVU, INST_REMU: begin end
            default: begin end
        endcase
    end

    // Iterate on magnitudes; the remainder follows the dividend's sign only.
    assign neg1    = sgn1 && rs1_data_i[XLEN-1];
    assign neg2    = sgn2 && rs2_data_i[XLEN-1];
    assign abs1    = neg1 ? -rs1_data_i : rs1_data_i;
    assign abs2    = neg2 ? -rs2_data_i : rs2_data_i;
    assign neg_res = (func3_i[2] && func3_i[1]) ? neg1 : (neg1 ^ neg2);

    assign div_zero = func3_i[2] && (rs2_data_i == '0);
    assign div_ovf  = ((func3_i == INST_DIV) || (func3_i == INST_REM)) &&
                      (rs1_data_i == MIN_NEG) && (rs2_data_i == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        if (div_zero) special_res = func3_i[1] ? rs1_data_i : '1;
        else          special_res = func3_i[1] ? '0 : rs1_data_i;
    end

    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_nxt = {mul_sum, prod_q[XLEN-1:1]};
    assign prod_s   = neg_q ? -prod_nxt : prod_nxt;

    ex_mdu_div #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step     (state_q == ST_CALC),
        .dividend (abs1),
        .divisor  (abs2),
        .quot_nxt (quot_nxt),
        .rem_nxt  (rem_nxt)
    );

    // Result is taken from the final step's next values so DONE carries it.
    always_comb begin
        if (!func3_q[2])            calc_res = (func3_q == INST_MUL) ? prod_s[XLEN-1:0]
                                                                     : prod_s[2*XLEN-1:XLEN];
        else if (func3_q[1])        calc_res = neg_q ? -rem_nxt : rem_nxt;
        else                        calc_res = neg_q ? -quot_nxt : quot_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_nxt = special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (flush_i)        state_nxt = ST_IDLE;
                else if (last_step) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_flag_o = accept || (state_q == ST_CALC);
        rd_wen_o    = (state_q == ST_DONE) && rd_wen_q && !flush_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            func3_q   <= '0;
            rd_addr_q <= '0;
            rd_wen_q  <= 1'b0;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            prod_q    <= '0;
            rd_data_o <= '0;
            rd_addr_o <= '0;
        end else if (accept) begin
            func3_q   <= func3_i;
            rd_addr_q <= rd_addr_i;
            rd_wen_q  <= rd_wen_i;
            neg_q     <= neg_res;
            mcand_q   <= abs1;
            prod_q    <= {{XLEN{1'b0}}, abs2};
            cnt_q     <= CW'(XLEN);
            if (special) begin
                rd_data_o <= special_res;
                rd_addr_o <= rd_addr_i;
            end
        end else if ((state_q == ST_CALC) && !flush_i) begin
            prod_q <= prod_nxt;
            cnt_q  <= cnt_q - CW'(1);
            if (last_step) begin
                rd_data_o <= calc_res;
                rd_addr_o <= rd_addr_q;
            end
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: vector table plus flush/reset/start-collision sequences.
module tb_ex_mdu;
    import ex_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        rd_wen_i = 1'b0;
    logic [2:0]  func3_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wen_o;
    logic        hold_flag_o;

    ex_mdu #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .func3_i     (func3_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .rd_addr_i   (rd_addr_i),
        .rd_wen_i    (rd_wen_i),
        .flush_i     (flush_i),
        .rd_addr_o   (rd_addr_o),
        .rd_data_o   (rd_data_o),
        .rd_wen_o    (rd_wen_o),
        .hold_flag_o (hold_flag_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[18];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next sampling point and retire any writeback against the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        #1;
        if (rd_wen_o === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb_unexpected: rd_wen_o=1 addr=0x%h at cycle %0d, want no writeback", rd_addr_o, cyc);
            end else begin
                e = sb.pop_front();
                check("wb_data", rd_data_o, e.data);
                check("wb_addr", {27'b0, rd_addr_o}, {27'b0, e.addr});
                check("wb_cycle", cyc, e.cyc);
            end
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input int lat,
                          input logic [4:0] addr, input logic wen);
        int s;
        int hold_bad;
        exp_t e;
        start_i    = 1'b1;
        flush_i    = 1'b0;
        func3_i    = f3;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_addr_i  = addr;
        rd_wen_i   = wen;
        #1;
        s = cyc;
        check({name, "_hold_start"}, {31'b0, hold_flag_o}, 32'd1);
        if (wen) begin
            e.data = res;
            e.addr = addr;
            e.cyc  = s + lat;
            sb.push_back(e);
        end
        tick();
        start_i    = 1'b0;
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
        rd_addr_i  = 5'($urandom);
        rd_wen_i   = ~wen;
        hold_bad   = 0;
        for (int k = 1; k < lat; k++) begin
            if (hold_flag_o !== 1'b1) hold_bad++;
            tick();
        end
        if (lat > 1) check({name, "_hold_calc"}, hold_bad, 0);
        check({name, "_hold_done"}, {31'b0, hold_flag_o}, 32'd0);
        check({name, "_wen_done"}, {31'b0, rd_wen_o}, {31'b0, wen});
        check({name, "_data"}, rd_data_o, res);
        check({name, "_sb_empty"}, sb.size(), 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{INST_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{INST_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{INST_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{INST_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[4]  = '{INST_MULH,   32'hFFFF_FFFD,  32'd7,         32'hFFFF_FFFF, 33};
        vecs[5]  = '{INST_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[6]  = '{INST_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[7]  = '{INST_DIVU,   32'd100,        32'd7,         32'd14,        33};
        vecs[8]  = '{INST_REMU,   32'd100,        32'd7,         32'd2,         33};
        vecs[9]  = '{INST_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[10] = '{INST_REM,    32'd5,          32'd0,         32'd5,         1};
        vecs[11] = '{INST_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[12] = '{INST_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[13] = '{INST_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[14] = '{INST_REMU,   32'd7,          32'd0,         32'd7,         1};
        vecs[15] = '{INST_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33};
        vecs[16] = '{INST_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[17] = '{INST_MUL,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};

        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_data", rd_data_o, 32'd0);
        check("rst_addr", {27'b0, rd_addr_o}, 32'd0);
        check("rst_wen", {31'b0, rd_wen_o}, 32'd0);
        check("rst_hold", {31'b0, hold_flag_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].lat, 5'(i + 1), 1'b1);

        // Flush in the middle of CALC, then restart the very next cycle.
        start_i = 1'b1; func3_i = INST_MUL; rs1_data_i = 32'd3; rs2_data_i = 32'd5;
        rd_addr_i = 5'd9; rd_wen_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_hold", {31'b0, hold_flag_o}, 32'd0);
        run_op("post_flush", INST_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, 33, 5'd10, 1'b1);

        // Start together with flush in IDLE must not be accepted.
        start_i = 1'b1; flush_i = 1'b1; func3_i = INST_DIV; rs1_data_i = 32'd5;
        rs2_data_i = 32'd0; rd_addr_i = 5'd3; rd_wen_i = 1'b1;
        #1;
        check("sf_hold", {31'b0, hold_flag_o}, 32'd0);
        tick();
        start_i = 1'b0; flush_i = 1'b0;
        check("sf_idle_hold", {31'b0, hold_flag_o}, 32'd0);
        tick();
        tick();

        // Asynchronous reset mid-calculation.
        start_i = 1'b1; func3_i = INST_MUL; rs1_data_i = 32'd9; rs2_data_i = 32'd9;
        rd_addr_i = 5'd4; rd_wen_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("arst_data", rd_data_o, 32'd0);
        check("arst_addr", {27'b0, rd_addr_o}, 32'd0);
        check("arst_wen", {31'b0, rd_wen_o}, 32'd0);
        check("arst_hold", {31'b0, hold_flag_o}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_op("post_rst", INST_MUL, 32'd9, 32'd9, 32'd81, 33, 5'd4, 1'b1);
        run_op("no_wen", INST_DIVU, 32'd100, 32'd7, 32'd14, 33, 5'd5, 1'b0);
        run_op("no_wen_special", INST_REM, 32'd11, 32'd0, 32'd11, 1, 5'd6, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
